// File: rtl/cordic_cmd_sequencer_if.sv
// rtl/cordic_cmd_sequencer_if.sv - request, response and calculator bundle for cordic_cmd_sequencer
//
// Ports (signals of the bundle):
//   req_valid/req_ready     request handshake, req_op/req_x/req_y/req_z payload
//   rsp_valid/rsp_ready     response handshake, rsp_result/rsp_op/rsp_error payload
//   calc_enable             hold-high enable to the CORDIC calculator
//   calc_operation/x/y/z    operands presented to the calculator
//   calc_result/calc_done   result and completion strobe from the calculator
// Modports:
//   slave   the sequencer
//   master  the environment (requester, response consumer and calculator)

interface cordic_cmd_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_x;
   logic [WIDTH-1:0] req_y;
   logic [WIDTH-1:0] req_z;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_op;
   logic             rsp_error;

   logic             calc_enable;
   logic [3:0]       calc_operation;
   logic [WIDTH-1:0] calc_x;
   logic [WIDTH-1:0] calc_y;
   logic [WIDTH-1:0] calc_z;
   logic [WIDTH-1:0] calc_result;
   logic             calc_done;

   modport slave (
      input  req_valid, req_op, req_x, req_y, req_z,
      output req_ready,
      output rsp_valid, rsp_result, rsp_op, rsp_error,
      input  rsp_ready,
      output calc_enable, calc_operation, calc_x, calc_y, calc_z,
      input  calc_result, calc_done
   );

   modport master (
      output req_valid, req_op, req_x, req_y, req_z,
      input  req_ready,
      input  rsp_valid, rsp_result, rsp_op, rsp_error,
      output rsp_ready,
      input  calc_enable, calc_operation, calc_x, calc_y, calc_z,
      output calc_result, calc_done
   );
endinterface

// File: rtl/cordic_cmd_sequencer.sv
// rtl/cordic_cmd_sequencer.sv - buffered command front-end for the CORDIC calculator
//
// Buffers requests in a DEPTH-entry FIFO and runs them one at a time on the
// calculator, holding operands and enable until calc_done, then returns the
// captured result on the response handshake. Ops 10-15 are answered with an
// error response without ever enabling the calculator.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   bus         cordic_cmd_sequencer_if.slave: req_*, rsp_*, calc_* signals
//   fifo_level  number of buffered requests (0..DEPTH)
//
// Optional feature macro: CORDIC_SEQ_TIMEOUT_EN
//   When defined, a command that has not seen calc_done by its TIMEOUT-th
//   BUSY cycle is answered with rsp_error=1 and rsp_result=0.

module cordic_cmd_sequencer #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4
`ifdef CORDIC_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 64
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   cordic_cmd_sequencer_if.slave  bus,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
   localparam logic [3:0]    LAST_OP    = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Request FIFO storage and pointers; pointers wrap naturally at DEPTH.
   logic [3:0]       fifo_op [DEPTH];
   logic [WIDTH-1:0] fifo_x  [DEPTH];
   logic [WIDTH-1:0] fifo_y  [DEPTH];
   logic [WIDTH-1:0] fifo_z  [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [3:0]       head_op;

   // Command registers drive the calculator operands directly, so they keep
   // the last command once the FSM leaves BUSY.
   logic [3:0]       cmd_op;
   logic [WIDTH-1:0] cmd_x;
   logic [WIDTH-1:0] cmd_y;
   logic [WIDTH-1:0] cmd_z;

   logic [WIDTH-1:0] rsp_result_q;
   logic [3:0]       rsp_op_q;
   logic             rsp_error_q;

   logic             load_cmd;
   logic             cap_done;
   logic             cap_fault;
   logic             calc_en;

`ifdef CORDIC_SEQ_TIMEOUT_EN
   localparam int            CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_BUSY = CW'(TIMEOUT - 1);
   logic [CW-1:0]            busy_cnt;
`endif

   assign full       = (count == FULL_LEVEL);
   assign empty      = (count == '0);
   // No pass-through: a full FIFO refuses even when a pop happens this cycle.
   assign push       = bus.req_valid && !full;
   assign head_op    = fifo_op[rd_ptr];
   assign fifo_level = count;

   assign bus.req_ready      = !full;
   assign bus.rsp_valid      = (state == RESP);
   assign bus.rsp_result     = rsp_result_q;
   assign bus.rsp_op         = rsp_op_q;
   assign bus.rsp_error      = rsp_error_q;
   assign bus.calc_enable    = calc_en;
   assign bus.calc_operation = cmd_op;
   assign bus.calc_x         = cmd_x;
   assign bus.calc_y         = cmd_y;
   assign bus.calc_z         = cmd_z;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_cmd   = 1'b0;
      cap_done   = 1'b0;
      cap_fault  = 1'b0;
      calc_en    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head_op <= LAST_OP) begin
                  load_cmd   = 1'b1;
                  state_next = BUSY;
               end else begin
                  // Unsupported op: straight to an error response.
                  cap_fault  = 1'b1;
                  state_next = RESP;
               end
            end
         end
         BUSY: begin
            calc_en = 1'b1;
            if (bus.calc_done) begin
               cap_done   = 1'b1;
               state_next = RESP;
            end
`ifdef CORDIC_SEQ_TIMEOUT_EN
            // calc_done on the last allowed cycle still wins above.
            else if (busy_cnt == LAST_BUSY) begin
               cap_fault  = 1'b1;
               state_next = RESP;
            end
`endif
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr] <= bus.req_op;
         fifo_x[wr_ptr]  <= bus.req_x;
         fifo_y[wr_ptr]  <= bus.req_y;
         fifo_z[wr_ptr]  <= bus.req_z;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_op       <= '0;
         cmd_x        <= '0;
         cmd_y        <= '0;
         cmd_z        <= '0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         if (load_cmd) begin
            cmd_op <= head_op;
            cmd_x  <= fifo_x[rd_ptr];
            cmd_y  <= fifo_y[rd_ptr];
            cmd_z  <= fifo_z[rd_ptr];
         end
         if (pop) begin
            rsp_op_q <= head_op;
         end
         if (cap_done) begin
            rsp_result_q <= bus.calc_result;
            rsp_error_q  <= 1'b0;
         end
         if (cap_fault) begin
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
         end
      end
   end

`ifdef CORDIC_SEQ_TIMEOUT_EN
   // Zero whenever not BUSY, so it starts from zero on every BUSY entry.
   always_ff @(posedge clk) begin
      if (rst || state != BUSY) begin
         busy_cnt <= '0;
      end else begin
         busy_cnt <= busy_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cordic_cmd_sequencer.sv
// tb/tb_cordic_cmd_sequencer.sv - self-checking bench for cordic_cmd_sequencer

module tb_cordic_cmd_sequencer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef CORDIC_SEQ_TIMEOUT_EN
   localparam int TOUT  = 8;
`endif

   typedef struct {
      logic [3:0]       op;
      logic [WIDTH-1:0] res;
      logic             err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [LW-1:0] fifo_level;

   cordic_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

   cordic_cmd_sequencer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH)
`ifdef CORDIC_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT (TOUT)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb[$];
   int   n_rsp = 0;
   int   full_seen = 0;
   logic [WIDTH-1:0] last_res;
   logic [3:0]       last_op;
   logic             last_err;

   int  fixed_lat = 3;
   bit  rand_lat  = 1'b0;
   bit  calc_hang = 1'b0;
   bit  noise     = 1'b0;
   bit  rand_ready = 1'b0;
   int  calc_cnt = 0;
   int  cur_lat = 1;
   int  low_cnt = 0;
   int  en_starts = 0;
   int  last_en_len = 0;
   logic [3:0]       l_op;
   logic [WIDTH-1:0] l_x, l_y, l_z;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Calculator behaviour: MULT is Q16.16 x*z, other ops an arbitrary mix.
   function automatic logic [WIDTH-1:0] calc_fn(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
      logic signed [63:0] p;
      if (op == 4'd4) begin
         p = $signed(x) * $signed(z);
         return p[47:16];
      end
      return (x ^ {y[15:0], y[31:16]}) + z + {28'd0, op};
   endfunction

   function automatic exp_t make_exp(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
      exp_t e;
      e.op = op;
      if (op > 4'd9) begin
         e.res = '0;
         e.err = 1'b1;
      end else begin
`ifdef CORDIC_SEQ_TIMEOUT_EN
         e.res = calc_hang ? '0 : calc_fn(op, x, y, z);
         e.err = calc_hang;
`else
         e.res = calc_fn(op, x, y, z);
         e.err = 1'b0;
`endif
      end
      return e;
   endfunction

   // Calculator model: acts 1ns after each rising edge.
   initial begin
      bus.calc_done   = 1'b0;
      bus.calc_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.calc_enable === 1'b1) begin
            if (calc_cnt == 0) begin
               if (en_starts > 0) check("enable_gap_ge2", low_cnt >= 2, 1'b1);
               en_starts++;
               l_op = bus.calc_operation;
               l_x  = bus.calc_x;
               l_y  = bus.calc_y;
               l_z  = bus.calc_z;
               cur_lat = rand_lat ? int'($urandom_range(1, 6)) : fixed_lat;
            end else begin
               check("calc_op_stable", bus.calc_operation, l_op);
               check("calc_x_stable", bus.calc_x, l_x);
               check("calc_y_stable", bus.calc_y, l_y);
               check("calc_z_stable", bus.calc_z, l_z);
            end
            low_cnt = 0;
            calc_cnt++;
            if (!calc_hang && calc_cnt >= cur_lat) begin
               bus.calc_done   = 1'b1;
               bus.calc_result = calc_fn(l_op, l_x, l_y, l_z);
            end else begin
               bus.calc_done   = 1'b0;
               bus.calc_result = $urandom;
            end
         end else begin
            if (calc_cnt != 0) last_en_len = calc_cnt;
            calc_cnt = 0;
            low_cnt++;
            bus.calc_done   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.calc_result = $urandom;
         end
      end
   end

   // Scoreboard monitor on the falling edge: sees the values the next rising edge samples.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         check("req_ready_vs_level", bus.req_ready, fifo_level < DEPTH);
         if (fifo_level == DEPTH) full_seen++;
         if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               check("rsp_op", bus.rsp_op, sb[0].op);
               check("rsp_result", bus.rsp_result, sb[0].res);
               check("rsp_error", bus.rsp_error, sb[0].err);
               if (bus.rsp_ready === 1'b1) begin
                  last_res = bus.rsp_result;
                  last_op  = bus.rsp_op;
                  last_err = bus.rsp_error;
                  n_rsp++;
                  void'(sb.pop_front());
               end
            end
         end
         if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1)
            sb.push_back(make_exp(bus.req_op, bus.req_x, bus.req_y, bus.req_z));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [3:0] op, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
      bit acc = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_x     = x;
      bus.req_y     = y;
      bus.req_z     = z;
      for (int i = 0; i < 2000 && !acc; i++) begin
         acc = (bus.req_ready === 1'b1);
         cyc();
      end
      bus.req_valid = 1'b0;
      check("push_accepted", acc, 1'b1);
   endtask

   task automatic wait_rsp(input string tag, input int target);
      for (int i = 0; i < 3000 && n_rsp < target; i++) cyc();
      check(tag, n_rsp >= target, 1'b1);
   endtask

   initial begin
      int starts0;
      int rsp0;
      int full0;
      int busy_ok;
      bit drained;
      logic [3:0] op;

      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.req_z     = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;

      check("rst_fifo_level", fifo_level, 0);
      check("rst_req_ready", bus.req_ready, 1'b1);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_result", bus.rsp_result, 0);
      check("rst_rsp_op", bus.rsp_op, 0);
      check("rst_rsp_error", bus.rsp_error, 1'b0);
      check("rst_calc_enable", bus.calc_enable, 1'b0);
      check("rst_calc_operation", bus.calc_operation, 0);
      check("rst_calc_x", bus.calc_x, 0);
      check("rst_calc_y", bus.calc_y, 0);
      check("rst_calc_z", bus.calc_z, 0);

      // Single MULT with an 18-cycle calculator.
      bus.rsp_ready = 1'b1;
      fixed_lat = 18;
      starts0 = en_starts;
      rsp0 = n_rsp;
      push(4'd4, 32'h0002_0000, $urandom, 32'h0003_0000);
      check("mult_level_after_accept", fifo_level, 1);
      check("mult_enable_before_pop", bus.calc_enable, 1'b0);
      cyc();
      check("mult_enable_after_pop", bus.calc_enable, 1'b1);
      check("mult_level_after_pop", fifo_level, 0);
      wait_rsp("mult_wait", rsp0 + 1);
      check("mult_result", last_res, 32'h0006_0000);
      check("mult_op", last_op, 4'd4);
      check("mult_error", last_err, 1'b0);
      check("mult_enable_len", last_en_len, 18);
      check("mult_enable_count", en_starts, starts0 + 1);

      // Back-to-back burst that fills the FIFO.
      fixed_lat = 10;
      full0 = full_seen;
      rsp0 = n_rsp;
      for (int i = 0; i < 6; i++)
         push(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom);
      wait_rsp("burst_wait", rsp0 + 6);
      check("burst_saw_full", full_seen > full0, 1'b1);

      // Unsupported op.
      starts0 = en_starts;
      rsp0 = n_rsp;
      push(4'hC, $urandom, $urandom, $urandom);
      wait_rsp("badop_wait", rsp0 + 1);
      check("badop_error", last_err, 1'b1);
      check("badop_result", last_res, 0);
      check("badop_op", last_op, 4'hC);
      check("badop_no_enable", en_starts, starts0);

      // Consumer stalls with three queued.
      bus.rsp_ready = 1'b0;
      fixed_lat = 3;
      rsp0 = n_rsp;
      for (int i = 0; i < 3; i++)
         push(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom);
      for (int i = 0; i < 100 && bus.rsp_valid !== 1'b1; i++) cyc();
      check("hold_rsp_seen", bus.rsp_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("hold_rsp_valid", bus.rsp_valid, 1'b1);
         check("hold_calc_enable", bus.calc_enable, 1'b0);
         check("hold_fifo_level", fifo_level, 2);
      end
      check("hold_no_rsp_taken", n_rsp, rsp0);
      bus.rsp_ready = 1'b1;
      wait_rsp("hold_drain", rsp0 + 3);

      // Calculator that never finishes.
      calc_hang = 1'b1;
      rsp0 = n_rsp;
      push(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom);
`ifdef CORDIC_SEQ_TIMEOUT_EN
      wait_rsp("timeout_wait", rsp0 + 1);
      check("timeout_error", last_err, 1'b1);
      check("timeout_result", last_res, 0);
      check("timeout_enable_len", last_en_len, TOUT);
      calc_hang = 1'b0;
`else
      busy_ok = 0;
      repeat (200) begin
         cyc();
         if (bus.calc_enable === 1'b1 && bus.rsp_valid === 1'b0) busy_ok++;
      end
      check("hang_busy_200", busy_ok, 200);
      check("hang_no_rsp", n_rsp, rsp0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      calc_hang = 1'b0;
      check("hang_rst_enable", bus.calc_enable, 1'b0);
`endif

      // Reset during BUSY with two queued.
      fixed_lat = 40;
      for (int i = 0; i < 3; i++)
         push(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom);
      repeat (5) cyc();
      check("midrst_busy_enable", bus.calc_enable, 1'b1);
      check("midrst_busy_level", fifo_level, 2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midrst_enable", bus.calc_enable, 1'b0);
      check("midrst_level", fifo_level, 0);
      check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      check("midrst_req_ready", bus.req_ready, 1'b1);
      fixed_lat = 5;
      rsp0 = n_rsp;
      push(4'd7, $urandom, $urandom, $urandom);
      wait_rsp("midrst_fresh_wait", rsp0 + 1);
      check("midrst_fresh_op", last_op, 4'd7);
      check("midrst_fresh_error", last_err, 1'b0);

      // Randomised traffic with back-pressure and stray calc_done.
      rand_lat = 1'b1;
      noise = 1'b1;
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         repeat ($urandom_range(0, 2)) cyc();
         push(op, $urandom, $urandom, $urandom);
      end
      rand_ready = 1'b0;
      bus.rsp_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 3000 && !drained; i++) begin
         cyc();
         drained = (sb.size() == 0) && (fifo_level == 0) && (bus.rsp_valid === 1'b0)
                   && (bus.calc_enable === 1'b0);
      end
      noise = 1'b0;
      check("random_drained", drained, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
